// File: rtl/control_rgb_entrada.sv
// Keypad-to-BCD-memory sequencer for R/G/B colour entry: steers digit keys into the memory,
// converts each confirmed 3-digit entry to binary, range-checks it and commits the colour after B.
module control_rgb_entrada #(
    parameter int unsigned ERR_CYCLES = 25_000_000,
    parameter logic [4:0]  KEY_OK     = 5'hA,
    parameter logic [4:0]  KEY_ESC    = 5'hB,
    parameter logic [4:0]  KEY_CLR    = 5'hC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] digito,
    input  logic       cambio_digito,
    input  logic [4:0] mem_u,
    input  logic [4:0] mem_d,
    input  logic [4:0] mem_c,
    input  logic       mem_full,
    output logic [4:0] mem_digito,
    output logic       mem_cambio,
    output logic       mem_clr,
    output logic [1:0] canal,
    output logic       error,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       rgb_valid
);

    typedef enum logic [1:0] {
        ST_ENTRADA = 2'd0,
        ST_ESPERA  = 2'd1,
        ST_CALC    = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    localparam int unsigned      CNT_W    = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ERR_CYCLES - 1);

    function automatic logic [9:0] bcd3_to_bin(input logic [4:0] c, input logic [4:0] d,
                                               input logic [4:0] u);
        logic [9:0] c_w;
        logic [9:0] d_w;
        logic [9:0] u_w;
        c_w = {5'd0, c};
        d_w = {5'd0, d};
        u_w = {5'd0, u};
        return (c_w * 10'd100) + (d_w * 10'd10) + u_w;
    endfunction

    function automatic logic fits_byte(input logic [9:0] v);
        return (v <= 10'd255);
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       canal_q, canal_d;
    logic [7:0]       sh_r_q, sh_r_d;
    logic [7:0]       sh_g_q, sh_g_d;
    logic [7:0]       r_q, r_d;
    logic [7:0]       g_q, g_d;
    logic [7:0]       b_q, b_d;
    logic             rgb_valid_q, rgb_valid_d;
    logic             error_q, error_d;
    logic [4:0]       mem_digito_q, mem_digito_d;
    logic             mem_cambio_q, mem_cambio_d;
    logic             mem_clr_q, mem_clr_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [9:0]       val_s;
    logic             key_digit_s;

    // Next-state and next-output logic for the entry sequencer.
    always_comb begin
        state_d      = state_q;
        canal_d      = canal_q;
        sh_r_d       = sh_r_q;
        sh_g_d       = sh_g_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        rgb_valid_d  = 1'b0;
        error_d      = error_q;
        mem_digito_d = mem_digito_q;
        mem_cambio_d = 1'b0;
        mem_clr_d    = 1'b0;
        err_cnt_d    = err_cnt_q;
        val_s        = bcd3_to_bin(mem_c, mem_d, mem_u);
        key_digit_s  = (digito <= 5'd9);

        case (state_q)
            ST_ENTRADA: begin
                if (cambio_digito) begin
                    if (key_digit_s) begin
                        // A full memory silently drops further digits.
                        if (!mem_full) begin
                            mem_cambio_d = 1'b1;
                            mem_digito_d = digito;
                        end else begin
                            mem_cambio_d = 1'b0;
                        end
                    end else if (digito == KEY_OK) begin
                        state_d = ST_ESPERA;
                    end else if (digito == KEY_CLR) begin
                        mem_clr_d = 1'b1;
                    end else if (digito == KEY_ESC) begin
                        mem_clr_d = 1'b1;
                        canal_d   = 2'd0;
                        sh_r_d    = 8'd0;
                        sh_g_d    = 8'd0;
                    end else begin
                        state_d = ST_ENTRADA;
                    end
                end else begin
                    state_d = ST_ENTRADA;
                end
            end
            ST_ESPERA: begin
                state_d = ST_CALC;
            end
            ST_CALC: begin
                mem_clr_d = 1'b1;
                if (!fits_byte(val_s)) begin
                    state_d   = ST_ERROR;
                    error_d   = 1'b1;
                    err_cnt_d = '0;
                end else begin
                    state_d = ST_ENTRADA;
                    case (canal_q)
                        2'd0: begin
                            sh_r_d  = val_s[7:0];
                            canal_d = 2'd1;
                        end
                        2'd1: begin
                            sh_g_d  = val_s[7:0];
                            canal_d = 2'd2;
                        end
                        2'd2: begin
                            r_d         = sh_r_q;
                            g_d         = sh_g_q;
                            b_d         = val_s[7:0];
                            rgb_valid_d = 1'b1;
                            canal_d     = 2'd0;
                        end
                        default: begin
                            canal_d = 2'd0;
                        end
                    endcase
                end
            end
            ST_ERROR: begin
                if (err_cnt_q == CNT_LAST) begin
                    error_d = 1'b0;
                    state_d = ST_ENTRADA;
                end else begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_ENTRADA;
                error_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset aborts any entry or error window at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_ENTRADA;
            canal_q      <= 2'd0;
            sh_r_q       <= 8'd0;
            sh_g_q       <= 8'd0;
            r_q          <= 8'd0;
            g_q          <= 8'd0;
            b_q          <= 8'd0;
            rgb_valid_q  <= 1'b0;
            error_q      <= 1'b0;
            mem_digito_q <= 5'd0;
            mem_cambio_q <= 1'b0;
            mem_clr_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            canal_q      <= canal_d;
            sh_r_q       <= sh_r_d;
            sh_g_q       <= sh_g_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            rgb_valid_q  <= rgb_valid_d;
            error_q      <= error_d;
            mem_digito_q <= mem_digito_d;
            mem_cambio_q <= mem_cambio_d;
            mem_clr_q    <= mem_clr_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign mem_digito = mem_digito_q;
    assign mem_cambio = mem_cambio_q;
    assign mem_clr    = mem_clr_q;
    assign canal      = canal_q;
    assign error      = error_q;
    assign R          = r_q;
    assign G          = g_q;
    assign B          = b_q;
    assign rgb_valid  = rgb_valid_q;

endmodule

// File: tb/tb_control_rgb_entrada.sv
// Bench for control_rgb_entrada with an attached 3-digit BCD memory and a key-level
// reference model (decimal digit list, channel index, shadow and committed colour).
module tb_control_rgb_entrada;

    localparam int         ERRC  = 4;
    localparam logic [4:0] K_OK  = 5'hA;
    localparam logic [4:0] K_ESC = 5'hB;
    localparam logic [4:0] K_CLR = 5'hC;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] digito;
    logic       cambio_digito;
    logic [4:0] mem_u, mem_d, mem_c;
    logic       mem_full;
    logic [4:0] mem_digito;
    logic       mem_cambio, mem_clr;
    logic [1:0] canal;
    logic       error;
    logic [7:0] R, G, B;
    logic       rgb_valid;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    control_rgb_entrada #(.ERR_CYCLES(ERRC)) dut (
        .clk(clk), .reset(reset), .digito(digito), .cambio_digito(cambio_digito),
        .mem_u(mem_u), .mem_d(mem_d), .mem_c(mem_c), .mem_full(mem_full),
        .mem_digito(mem_digito), .mem_cambio(mem_cambio), .mem_clr(mem_clr),
        .canal(canal), .error(error), .R(R), .G(G), .B(B), .rgb_valid(rgb_valid)
    );

    // Digit memory: new digit enters the units position, older digits shift up.
    logic [4:0] m_c, m_d, m_u;
    int         m_n;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_c <= 5'd0; m_d <= 5'd0; m_u <= 5'd0; m_n <= 0;
        end else if (mem_clr) begin
            m_c <= 5'd0; m_d <= 5'd0; m_u <= 5'd0; m_n <= 0;
        end else if (mem_cambio && m_n < 3) begin
            m_c <= m_d; m_d <= m_u; m_u <= mem_digito; m_n <= m_n + 1;
        end
    end
    assign mem_c = m_c;
    assign mem_d = m_d;
    assign mem_u = m_u;
    assign mem_full = (m_n == 3);

    // Pulse/level observers sampled mid-cycle.
    int obs_cambio = 0, obs_clr = 0, obs_valid = 0, obs_err = 0, obs_overlap = 0;
    always @(negedge clk) begin
        if (mem_cambio) obs_cambio++;
        if (mem_clr) obs_clr++;
        if (rgb_valid) obs_valid++;
        if (error) obs_err++;
        if (mem_cambio && mem_clr) obs_overlap++;
    end

    // Reference model state.
    int dq[$];
    int canal_m = 0, shr = 0, shg = 0, rm = 0, gm = 0, bm = 0;
    int exp_cambio = 0, exp_clr = 0, exp_valid = 0, exp_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle key strobe; returns 1 time unit after the edge that captured it.
    task automatic strobe(input logic [4:0] k);
        @(posedge clk); #1;
        digito = k;
        cambio_digito = 1'b1;
        @(posedge clk); #1;
        cambio_digito = 1'b0;
    endtask

    task automatic check_state();
        check("canal", canal, canal_m);
        check("R", R, rm);
        check("G", G, gm);
        check("B", B, bm);
        check("error_idle", error, 0);
        check("n_cambio", obs_cambio, exp_cambio);
        check("n_clr", obs_clr, exp_clr);
        check("n_valid", obs_valid, exp_valid);
        check("n_err_cycles", obs_err, exp_err);
    endtask

    task automatic key(input logic [4:0] k);
        int  val;
        bit  accepted;
        bit  too_big;
        bit  commit;
        strobe(k);
        if (k <= 5'd9) begin
            accepted = (dq.size() < 3);
            check("mem_cambio", mem_cambio, accepted);
            if (accepted) begin
                check("mem_digito", mem_digito, k);
                dq.push_back(int'(k));
                exp_cambio++;
            end
            idle(2);
        end else if (k == K_OK) begin
            val = 0;
            foreach (dq[i]) val = val * 10 + dq[i];
            dq.delete();
            too_big = (val > 255);
            commit  = !too_big && (canal_m == 2);
            exp_clr++;
            if (too_big) begin
                exp_err += ERRC;
            end else if (canal_m == 0) begin
                shr = val; canal_m = 1;
            end else if (canal_m == 1) begin
                shg = val; canal_m = 2;
            end else begin
                rm = shr; gm = shg; bm = val; canal_m = 0; exp_valid++;
            end
            idle(1);
            check("ok_clr_early", mem_clr, 0);
            idle(1);
            check("ok_clr", mem_clr, 1);
            check("ok_error", error, too_big);
            check("ok_valid", rgb_valid, commit);
            if (commit) begin
                check("ok_R", R, rm);
                check("ok_G", G, gm);
                check("ok_B", B, bm);
            end
            idle(6);
        end else if (k == K_CLR || k == K_ESC) begin
            check("key_clr", mem_clr, 1);
            dq.delete();
            exp_clr++;
            if (k == K_ESC) begin
                canal_m = 0; shr = 0; shg = 0;
            end
            idle(2);
        end else begin
            check("junk_cambio", mem_cambio, 0);
            check("junk_clr", mem_clr, 0);
            idle(2);
        end
        check_state();
    endtask

    task automatic number(input int v);
        if (v >= 100) key(5'(v / 100));
        if (v >= 10) key(5'((v / 10) % 10));
        key(5'(v % 10));
        key(K_OK);
    endtask

    initial begin
        int r;
        reset = 1'b0;
        digito = 5'd0;
        cambio_digito = 1'b0;
        idle(3);
        check("rst_canal", canal, 0);
        check("rst_R", R, 0);
        check("rst_valid", rgb_valid, 0);
        check("rst_clr", mem_clr, 0);
        check("rst_cambio", mem_cambio, 0);
        reset = 1'b1;
        idle(2);

        // T1: R=255 G=128 B=0.
        number(255);
        number(128);
        number(0);
        // T2: out-of-range entry.
        number(256);
        // T3: fourth digit dropped, channel value 123 seen on commit.
        key(5'd1); key(5'd2); key(5'd3); key(5'd4); key(K_OK);
        number(45);
        number(6);
        // Clear mid-entry holds the channel.
        key(5'd7); key(K_CLR); key(5'd8); key(K_OK);
        // T4: abort after R and G.
        number(20);
        number(30);
        key(K_ESC);
        // Junk codes ignored.
        key(5'hD); key(5'hE); key(5'hF); key(5'h13);
        // T5: keys during ERROR are ignored.
        key(5'd9); key(5'd9); key(5'd9);
        strobe(K_OK);
        dq.delete();
        exp_clr++;
        exp_err += ERRC;
        idle(2);
        check("t5_error", error, 1);
        strobe(5'd5);
        check("t5_cambio", mem_cambio, 0);
        strobe(K_OK);
        idle(6);
        check_state();
        key(5'd2);
        key(K_OK);
        // T6: reset asserted while in ESPERA.
        key(5'd3);
        strobe(K_OK);
        #2;
        reset = 1'b0;
        #1;
        check("t6_canal", canal, 0);
        check("t6_R", R, 0);
        check("t6_G", G, 0);
        check("t6_B", B, 0);
        check("t6_clr", mem_clr, 0);
        check("t6_error", error, 0);
        dq.delete();
        canal_m = 0; shr = 0; shg = 0; rm = 0; gm = 0; bm = 0;
        idle(2);
        reset = 1'b1;
        idle(1);
        key(5'd0);
        key(K_OK);
        check("t6_after", canal, 1);

        // Randomized key stream.
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 19);
            if (r < 12)       key(5'($urandom_range(0, 9)));
            else if (r < 15)  key(K_OK);
            else if (r == 15) key(K_CLR);
            else if (r == 16) key(K_ESC);
            else if (r == 17) key(5'($urandom_range(13, 15)));
            else              key(5'(16 + $urandom_range(0, 15)));
        end
        for (int i = 0; i < 3; i++) number($urandom_range(0, 255));

        check("no_overlap", obs_overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
